tour_cmd: RTL and testbench



---
 rtl/tour_pkg.sv | 47 ++++
 rtl/tour_cmd_if.sv | 28 ++
 rtl/tour_move_decode.sv | 35 +++
 rtl/tour_cmd.sv | 109 ++++++++++
 tb/tb_tour_cmd.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command replay block:
// move codes, command opcodes/headings, response bytes and FSM states.
package tour_pkg;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    // Move codes named by (dx, dy): P = plus, M = minus, digit = magnitude.
    typedef enum logic [3:0] {
        MV_P2P1 = 4'd1,
        MV_P1P2 = 4'd2,
        MV_M1P2 = 4'd3,
        MV_M2P1 = 4'd4,
        MV_M2M1 = 4'd5,
        MV_M1M2 = 4'd6,
        MV_P1M2 = 4'd7,
        MV_P2M1 = 4'd8
    } move_e;

    localparam logic [3:0] CMD_MOVE     = 4'h2;
    localparam logic [3:0] CMD_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_HOLD_V,
        ST_RESP_V,
        ST_HORZ,
        ST_HOLD_H,
        ST_RESP_H
    } state_e;

    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [1:0] mag);
        return {op, hdg, 2'b00, mag};
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Bundle of solver, UART and command-processor signals around tour_cmd.
// The slave modport is the tour_cmd view; master is the surrounding system.
interface tour_cmd_if;
    import tour_pkg::*;

    logic             start_tour;
    logic [3:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy_UART;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic [7:0]       resp;

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

endinterface

// File: rtl/tour_move_decode.sv
// Combinational expansion of a 4-bit knight move code into signed leg
// magnitudes; codes outside 1..8 are flagged invalid.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [3:0] i_move,
    output logic       o_dy_neg,
    output logic [1:0] o_dy_mag,
    output logic       o_dx_neg,
    output logic [1:0] o_dx_mag,
    output logic       o_valid
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        o_dy_neg = 1'b0;
        o_dy_mag = 2'd0;
        o_dx_neg = 1'b0;
        o_dx_mag = 2'd0;
        o_valid  = 1'b1;
        case (i_move)
            MV_P2P1: begin o_dx_mag = 2'd2; o_dy_mag = 2'd1; end
            MV_P1P2: begin o_dx_mag = 2'd1; o_dy_mag = 2'd2; end
            MV_M1P2: begin o_dx_neg = 1'b1; o_dx_mag = 2'd1; o_dy_mag = 2'd2; end
            MV_M2P1: begin o_dx_neg = 1'b1; o_dx_mag = 2'd2; o_dy_mag = 2'd1; end
            MV_M2M1: begin o_dx_neg = 1'b1; o_dx_mag = 2'd2; o_dy_neg = 1'b1; o_dy_mag = 2'd1; end
            MV_M1M2: begin o_dx_neg = 1'b1; o_dx_mag = 2'd1; o_dy_neg = 1'b1; o_dy_mag = 2'd2; end
            MV_P1M2: begin o_dx_mag = 2'd1; o_dy_neg = 1'b1; o_dy_mag = 2'd2; end
            MV_P2M1: begin o_dx_mag = 2'd2; o_dy_neg = 1'b1; o_dy_mag = 2'd1; end
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as vertical/horizontal robot commands and
// muxes them with UART commands in front of the command processor.
module tour_cmd
    import tour_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    tour_cmd_if.slave  bus
);

    state_e           r_state;
    state_e           w_next_state;
    logic [IDX_W-1:0] r_mv_indx;
    logic [IDX_W-1:0] w_next_mv_indx;

    logic        w_dy_neg;
    logic [1:0]  w_dy_mag;
    logic        w_dx_neg;
    logic [1:0]  w_dx_mag;
    logic        w_valid;
    logic [15:0] w_vert_cmd;
    logic [15:0] w_horz_cmd;
    logic        w_last;

    tour_move_decode u_decode (
        .i_move   (bus.move),
        .o_dy_neg (w_dy_neg),
        .o_dy_mag (w_dy_mag),
        .o_dx_neg (w_dx_neg),
        .o_dx_mag (w_dx_mag),
        .o_valid  (w_valid)
    );

    assign w_vert_cmd  = make_cmd(CMD_MOVE,     w_dy_neg ? HDG_S : HDG_N, w_dy_mag);
    assign w_horz_cmd  = make_cmd(CMD_MOVE_FAN, w_dx_neg ? HDG_W : HDG_E, w_dx_mag);
    assign w_last      = (r_mv_indx == IDX_W'(NUM_MOVES - 1));
    assign bus.mv_indx = r_mv_indx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mv_indx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_mv_indx <= w_next_mv_indx;
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_next_mv_indx       = r_mv_indx;
        bus.cmd              = w_vert_cmd;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_ACK;
        case (r_state)
            ST_IDLE: begin
                bus.cmd  = bus.cmd_UART;
                bus.resp = RESP_DONE;
                if (bus.start_tour) begin
                    // UART request is held off this cycle so it stays pending.
                    w_next_state   = ST_VERT;
                    w_next_mv_indx = '0;
                end else begin
                    bus.cmd_rdy          = bus.cmd_rdy_UART;
                    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                end
            end
            ST_VERT: begin
                bus.cmd_rdy = 1'b1;
                if (!w_valid)             w_next_state = ST_IDLE;
                else if (bus.clr_cmd_rdy) w_next_state = ST_RESP_V;
            end
            ST_HOLD_V: begin
                if (!w_valid)             w_next_state = ST_IDLE;
                else if (bus.clr_cmd_rdy) w_next_state = ST_RESP_V;
            end
            ST_RESP_V: begin
                if (bus.send_resp) w_next_state = ST_HORZ;
            end
            ST_HORZ: begin
                bus.cmd     = w_horz_cmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) w_next_state = ST_RESP_H;
            end
            ST_HOLD_H: begin
                bus.cmd = w_horz_cmd;
                if (bus.clr_cmd_rdy) w_next_state = ST_RESP_H;
            end
            ST_RESP_H: begin
                bus.cmd = w_horz_cmd;
                if (w_last) bus.resp = RESP_DONE;
                if (bus.send_resp) begin
                    if (w_last) begin
                        w_next_state   = ST_IDLE;
                        w_next_mv_indx = '0;
                    end else begin
                        w_next_state   = ST_VERT;
                        w_next_mv_indx = r_mv_indx + IDX_W'(1);
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: expected commands are queued when a tour
// is launched and compared as the DUT presents them to the consumer model.
module tb_tour_cmd;
    import tour_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    tour_cmd_if bus();

    tour_cmd u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Solver model: move code is a combinational lookup on mv_indx.
    logic [3:0] tour_tbl [32];
    assign bus.move = tour_tbl[bus.mv_indx];

    int dxs [9] = '{0, 2, 1, -1, -2, -2, -1, 1, 2};
    int dys [9] = '{0, 1, 2, 2, 1, -1, -2, -2, -1};
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_move(input int code);
        int dx = dxs[code];
        int dy = dys[code];
        exp_q.push_back({4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)});
        exp_q.push_back({4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)});
    endtask

    task automatic start_tour();
        bus.start_tour = 1'b1;
        @(negedge clk);
        bus.start_tour = 1'b0;
        check("start_lat", bus.cmd_rdy, 1);
    endtask

    // Consumer model: wait for cmd_rdy, take the command, optionally respond.
    task automatic serve(input string tag, input bit do_resp, input bit last);
        int          wait_n = 0;
        logic [15:0] exp;
        while (bus.cmd_rdy !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (bus.cmd_rdy !== 1'b1) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 0, 1);
            return;
        end
        exp = exp_q.pop_front();
        check({tag, "_cmd"}, bus.cmd, exp);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        check({tag, "_uart_clr"}, bus.clr_cmd_rdy_UART, 0);
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        check({tag, "_rdy_low"}, bus.cmd_rdy, 0);
        check({tag, "_held"}, bus.cmd, exp);
        check({tag, "_resp"}, bus.resp, last ? 8'h5A : 8'hA5);
        if (do_resp) begin
            bus.send_resp = 1'b1;
            @(negedge clk);
            bus.send_resp = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tour_tbl[i] = 4'd0;
        rst_n            = 1'b0;
        bus.start_tour   = 1'b0;
        bus.cmd_UART     = 16'h2003;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;

        // Reset state and idle pass-through
        #1;
        check("rst_cmd", bus.cmd, 16'h2003);
        check("rst_rdy", bus.cmd_rdy, 1);
        check("rst_resp", bus.resp, 8'h5A);
        check("rst_idx", bus.mv_indx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        check("idle_clr", bus.clr_cmd_rdy_UART, 1);
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;

        // Single move, then invalid code at index 1 drops back to idle
        bus.cmd_UART     = 16'h1234;
        bus.cmd_rdy_UART = 1'b0;
        tour_tbl[0] = 4'd1;
        tour_tbl[1] = 4'd0;
        push_move(1);
        start_tour();
        serve("m1_v", 1, 0);
        serve("m1_h", 1, 0);
        check("m1_idx", bus.mv_indx, 1);
        @(negedge clk);
        check("m1_inv_resp", bus.resp, 8'h5A);
        check("m1_inv_cmd", bus.cmd, 16'h1234);
        check("m1_inv_rdy", bus.cmd_rdy, 0);

        // Negative legs
        tour_tbl[0] = 4'd6;
        tour_tbl[1] = 4'd12;
        push_move(6);
        start_tour();
        serve("neg_v", 1, 0);
        serve("neg_h", 1, 0);
        @(negedge clk);
        check("neg_idle", bus.resp, 8'h5A);

        // Invalid codes at index 0
        tour_tbl[0] = 4'd0;
        start_tour();
        @(negedge clk);
        check("inv0_resp", bus.resp, 8'h5A);
        check("inv0_rdy", bus.cmd_rdy, 0);
        tour_tbl[0] = 4'd12;
        start_tour();
        @(negedge clk);
        check("inv12_resp", bus.resp, 8'h5A);
        check("inv12_cmd", bus.cmd, 16'h1234);

        // Full tour with codes 1..8 cycling; UART request kept pending throughout
        bus.cmd_rdy_UART = 1'b1;
        for (int i = 0; i < NUM_MOVES; i++) tour_tbl[i] = 4'((i % 8) + 1);
        for (int i = 0; i < NUM_MOVES; i++) push_move((i % 8) + 1);
        start_tour();
        for (int i = 0; i < NUM_MOVES; i++) begin
            check($sformatf("tour_idx%0d", i), bus.mv_indx, i);
            serve($sformatf("tour%0d_v", i), 1, 0);
            serve($sformatf("tour%0d_h", i), 1, i == NUM_MOVES - 1);
        end
        check("tour_end_idx", bus.mv_indx, 0);
        check("tour_end_resp", bus.resp, 8'h5A);
        check("tour_end_cmd", bus.cmd, 16'h1234);
        check("tour_end_rdy", bus.cmd_rdy, 1);
        check("tour_q_empty", exp_q.size(), 0);

        // Async reset while in RESP_V at index 7
        for (int i = 0; i < 8; i++) push_move((i % 8) + 1);
        start_tour();
        for (int i = 0; i < 7; i++) begin
            serve($sformatf("rst%0d_v", i), 1, 0);
            serve($sformatf("rst%0d_h", i), 1, 0);
        end
        check("rst_pre_idx", bus.mv_indx, 7);
        serve("rst7_v", 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", bus.cmd_rdy, 1);
        check("arst_idx", bus.mv_indx, 0);
        check("arst_resp", bus.resp, 8'h5A);
        check("arst_cmd", bus.cmd, 16'h1234);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        push_move(1);
        start_tour();
        check("restart_idx", bus.mv_indx, 0);
        serve("restart_v", 1, 0);
        check("restart_resp", bus.resp, 8'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
